ysyx_23060332_ctrl: RTL

Multi-cycle instruction sequencer for the NPC core.
- Owns the PC and the latched instruction register feeding the decode unit.
- Sequences fetch, decode/execute, memory access and writeback using valid/ready handshakes to the instruction-fetch and load/store memory ports.
- Gates the decoder's register write enable so the register file is written exactly once per retired instruction, in the writeback cycle.

---
 rtl/ysyx_23060332_ctrl_if.sv | 43 ++++
 rtl/ysyx_23060332_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ctrl_if.sv
// ysyx_23060332_ctrl_if
//   Handshake bundle between the instruction sequencer and its two memory
//   ports (instruction fetch and load/store).
//
//   ifu_req_valid / ifu_req_ready / ifu_req_addr : fetch request channel
//   ifu_rsp_valid / ifu_rsp_inst                 : fetch response channel
//   lsu_req_valid / lsu_req_ready                : load/store request channel
//   lsu_rsp_valid                                : load data ready / store done
//
//   master : the sequencer side (drives requests, receives responses)
//   slave  : the memory side
interface ysyx_23060332_ctrl_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst,
    output lsu_req_valid,
    input  lsu_req_ready,
    input  lsu_rsp_valid
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_inst,
    input  lsu_req_valid,
    output lsu_req_ready,
    output lsu_rsp_valid
  );
endinterface

// File: rtl/ysyx_23060332_ctrl.sv
// ysyx_23060332_ctrl
//   Multi-cycle instruction sequencer for the NPC core. Owns the PC and the
//   instruction register, steps each instruction through fetch, execute,
//   optional memory access and writeback, and gates the register-file write
//   so it happens exactly once, in the writeback cycle.
//
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   bus (master)  : fetch and load/store handshakes (see ysyx_23060332_ctrl_if)
//   inst_o, pc_o  : latched instruction and current PC for decode/execute
//   inst_valid    : inst_o is live (EXEC, MEM_REQ, MEM_WAIT, WB)
//   next_pc_i     : next PC from execute
//   reg_wen_i, rd_i : decoder write enable / destination register
//   reg_wen_o     : gated register-file write enable
//   ebreak_i, invalid_i : decoded ebreak / illegal instruction
//   halted, halt_err    : sticky halt status and error cause
//
// Optional feature macro YSYX_23060332_CTRL_PERF_EN adds the 64-bit
// perf_cycle and perf_instret counter outputs.
module ysyx_23060332_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [6:0]  OPC_LOAD  = 7'b0000011,
  parameter logic [6:0]  OPC_STORE = 7'b0100011
) (
  input  logic                clk,
  input  logic                rst_n,
  ysyx_23060332_ctrl_if.master bus,
  output logic [31:0]         inst_o,
  output logic [31:0]         pc_o,
  output logic                inst_valid,
  input  logic [31:0]         next_pc_i,
  input  logic                reg_wen_i,
  input  logic [4:0]          rd_i,
  output logic                reg_wen_o,
  input  logic                ebreak_i,
  input  logic                invalid_i,
  output logic                halted,
  output logic                halt_err
`ifdef YSYX_23060332_CTRL_PERF_EN
  ,
  output logic [63:0]         perf_cycle,
  output logic [63:0]         perf_instret
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        halt_err_reg, halt_err_next;

  logic [6:0]  opcode;
  logic        is_mem;
  logic        is_store;

  assign opcode   = inst_reg[6:0];
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = (opcode == OPC_LOAD) || is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH_REQ;
      pc_reg       <= RESET_PC;
      inst_reg     <= NOP;
      halt_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inst_reg     <= inst_next;
      halt_err_reg <= halt_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inst_next     = inst_reg;
    halt_err_next = halt_err_reg;
    case (state_reg)
      FETCH_REQ: begin
        if (bus.ifu_req_ready) begin
          if (bus.ifu_rsp_valid) begin
            inst_next  = bus.ifu_rsp_inst;
            state_next = EXEC;
          end else begin
            state_next = FETCH_WAIT;
          end
        end
      end
      FETCH_WAIT: begin
        if (bus.ifu_rsp_valid) begin
          inst_next  = bus.ifu_rsp_inst;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // Halt causes are checked in priority order before any dispatch.
        if (invalid_i) begin
          state_next    = HALT;
          halt_err_next = 1'b1;
        end else if (ebreak_i) begin
          state_next = HALT;
        end else if (next_pc_i[1:0] != 2'b00) begin
          state_next    = HALT;
          halt_err_next = 1'b1;
        end else if (is_mem) begin
          state_next = MEM_REQ;
        end else begin
          state_next = WB;
        end
      end
      MEM_REQ: begin
        if (bus.lsu_req_ready) begin
          state_next = bus.lsu_rsp_valid ? WB : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.lsu_rsp_valid) begin
          state_next = WB;
        end
      end
      WB: begin
        pc_next    = next_pc_i;
        state_next = FETCH_REQ;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH_REQ;
      end
    endcase
  end

  // Reset parks the FSM in FETCH_REQ, but no request may be presented while
  // reset is held, so the fetch valid is qualified with rst_n.
  assign bus.ifu_req_valid = (state_reg == FETCH_REQ) && rst_n;
  assign bus.ifu_req_addr  = pc_reg;
  assign bus.lsu_req_valid = (state_reg == MEM_REQ);

  assign inst_o     = inst_reg;
  assign pc_o       = pc_reg;
  assign inst_valid = (state_reg == EXEC) || (state_reg == MEM_REQ) ||
                      (state_reg == MEM_WAIT) || (state_reg == WB);
  // x0 is hard-wired and stores never write rd.
  assign reg_wen_o  = (state_reg == WB) && reg_wen_i && (rd_i != 5'd0) && !is_store;
  assign halted     = (state_reg == HALT);
  assign halt_err   = halt_err_reg;

`ifdef YSYX_23060332_CTRL_PERF_EN
  logic [63:0] perf_cycle_reg;
  logic [63:0] perf_instret_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycle_reg   <= 64'd0;
      perf_instret_reg <= 64'd0;
    end else if (state_reg != HALT) begin
      perf_cycle_reg <= perf_cycle_reg + 64'd1;
      if (state_reg == WB) begin
        perf_instret_reg <= perf_instret_reg + 64'd1;
      end
    end
  end

  assign perf_cycle   = perf_cycle_reg;
  assign perf_instret = perf_instret_reg;
`endif

endmodule
